// File: rtl/s018dp_ram_dp_w1024_m4.sv
// s018dp_ram_dp_w1024_m4
// Behavioural stand-in for the 1024-word true-dual-port synchronous SRAM macro.
// Both ports share one clock. Reads and writes each take one word per cycle.
// Read data is registered, and a write returns the merged post-write word.
// Optional feature macro: S018DP_BW_EN adds active-low per-bit write enables
// (bwena/bwenb) that model the _BW macro variants.
// On a same-address double write, port B wins on the bits both ports enable.
module s018dp_ram_dp_w1024_m4 #(
    parameter int DATA_WIDTH = 128,
    parameter int DATA_DEPTH = 1024,
    parameter int ADDR_WIDTH = $clog2(DATA_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cena,
    input  logic                  wena,
`ifdef S018DP_BW_EN
    input  logic [DATA_WIDTH-1:0] bwena,
`endif
    input  logic [ADDR_WIDTH-1:0] aa,
    input  logic [DATA_WIDTH-1:0] da,
    output logic [DATA_WIDTH-1:0] qa,
    input  logic                  cenb,
    input  logic                  wenb,
`ifdef S018DP_BW_EN
    input  logic [DATA_WIDTH-1:0] bwenb,
`endif
    input  logic [ADDR_WIDTH-1:0] ab,
    input  logic [DATA_WIDTH-1:0] db,
    output logic [DATA_WIDTH-1:0] qb
);

    // Addresses can only fall outside the array when the depth is not a power of two.
    localparam bit ADDR_POW2 = (DATA_DEPTH == (1 << ADDR_WIDTH));

    logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];

    logic                  in_range_a, in_range_b;
    logic                  wr_a, wr_b;
    logic                  same_addr;
    logic [DATA_WIDTH-1:0] mask_a, mask_b;
    logic [DATA_WIDTH-1:0] old_a, old_b;
    logic [DATA_WIDTH-1:0] final_a, final_b;

    assign in_range_a = ADDR_POW2 || (int'(aa) < DATA_DEPTH);
    assign in_range_b = ADDR_POW2 || (int'(ab) < DATA_DEPTH);

    assign wr_a = ~cena & ~wena & in_range_a;
    assign wr_b = ~cenb & ~wenb & in_range_b;

    assign same_addr = (aa == ab);

    // Effective write masks: active-high bits that this port writes this cycle.
`ifdef S018DP_BW_EN
    assign mask_a = wr_a ? ~bwena : '0;
    assign mask_b = wr_b ? ~bwenb : '0;
`else
    assign mask_a = wr_a ? '1 : '0;
    assign mask_b = wr_b ? '1 : '0;
`endif

    assign old_a = in_range_a ? mem[aa] : '0;
    assign old_b = in_range_b ? mem[ab] : '0;

    // Merge the stored word with the port writes. On a collision, A is applied
    // first and B second, so B wins on the bits both ports enable.
    always_comb begin
        final_a = (old_a & ~mask_a) | (da & mask_a);
        if (same_addr) begin
            final_a = (final_a & ~mask_b) | (db & mask_b);
        end
        final_b = old_b;
        if (same_addr) begin
            final_b = (final_b & ~mask_a) | (da & mask_a);
        end
        final_b = (final_b & ~mask_b) | (db & mask_b);
    end

    // Array update: contents survive reset, and no write happens while reset is held.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (wr_a) begin
                mem[aa] <= final_a;
            end
            if (wr_b) begin
                mem[ab] <= final_b;
            end
        end
    end

    // Port A output register: a read returns the old word, a write returns the merged word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qa <= '0;
        end else if (!cena) begin
            if (!in_range_a) begin
                qa <= '0;
            end else if (!wena) begin
                qa <= final_a;
            end else begin
                qa <= old_a;
            end
        end
    end

    // Port B output register: same behaviour as port A.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qb <= '0;
        end else if (!cenb) begin
            if (!in_range_b) begin
                qb <= '0;
            end else if (!wenb) begin
                qb <= final_b;
            end else begin
                qb <= old_b;
            end
        end
    end

endmodule

// File: tb/tb_s018dp_ram_dp_w1024_m4.sv
// Testbench for s018dp_ram_dp_w1024_m4 (default 128-bit x 1024 configuration).
// Build with S018DP_BW_EN defined to also exercise the per-bit write enables.
module tb_s018dp_ram_dp_w1024_m4;

    localparam int DW = 128;
    localparam int AW = 10;
    localparam int DEPTH = 1024;

    logic          clk;
    logic          rst_n;
    logic          cena, wena, cenb, wenb;
    logic [AW-1:0] aa, ab;
    logic [DW-1:0] da, db;
    logic [DW-1:0] qa, qb;
`ifdef S018DP_BW_EN
    logic [DW-1:0] bwena, bwenb;
`endif

    int errors;
    int checks;

    // Reference model: array contents and the expected registered outputs.
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] exp_qa, exp_qb;

    s018dp_ram_dp_w1024_m4 #(
        .DATA_WIDTH(DW),
        .DATA_DEPTH(DEPTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .cena (cena),
        .wena (wena),
`ifdef S018DP_BW_EN
        .bwena(bwena),
`endif
        .aa   (aa),
        .da   (da),
        .qa   (qa),
        .cenb (cenb),
        .wenb (wenb),
`ifdef S018DP_BW_EN
        .bwenb(bwenb),
`endif
        .ab   (ab),
        .db   (db),
        .qb   (qb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of both ports, advance past the rising edge and update the model.
    // bwa/bwb are active-low bit enables; pass '0 for full-word writes.
    task automatic apply(input logic ca, input logic wa, input logic [AW-1:0] a_addr,
                         input logic [DW-1:0] a_d, input logic [DW-1:0] bwa,
                         input logic cb, input logic wb, input logic [AW-1:0] b_addr,
                         input logic [DW-1:0] b_d, input logic [DW-1:0] bwb);
        logic [DW-1:0] old_a, old_b, ma, mb;
        cena = ca; wena = wa; aa = a_addr; da = a_d;
        cenb = cb; wenb = wb; ab = b_addr; db = b_d;
`ifdef S018DP_BW_EN
        bwena = bwa; bwenb = bwb;
        ma = ~bwa; mb = ~bwb;
`else
        ma = '1; mb = '1;
        if (bwa === 'x || bwb === 'x) ma = '1;
`endif
        @(posedge clk);
        if (rst_n) begin
            old_a = ref_mem[a_addr];
            old_b = ref_mem[b_addr];
            if (!ca && !wa) ref_mem[a_addr] = (ref_mem[a_addr] & ~ma) | (a_d & ma);
            if (!cb && !wb) ref_mem[b_addr] = (ref_mem[b_addr] & ~mb) | (b_d & mb);
            if (!ca) exp_qa = wa ? old_a : ref_mem[a_addr];
            if (!cb) exp_qb = wb ? old_b : ref_mem[b_addr];
        end
        #1;
    endtask

    task automatic idle();
        apply(1'b1, 1'b1, '0, '0, '0, 1'b1, 1'b1, '0, '0, '0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        idle();
        checks++;
        if (qa !== '0 || qb !== '0) begin
            errors++;
            $display("FAIL reset_state qa=%h qb=%h required 0", qa, qb);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_qa = '0;
        exp_qb = '0;
    endtask

    task automatic test_basic_rw();
        logic [DW-1:0] w;
        w = 128'h1234_5678;
        apply(1'b0, 1'b0, 10'd5, w, '0, 1'b1, 1'b1, '0, '0, '0);
        checks++;
        if (qa !== w) begin
            errors++;
            $display("FAIL basic_write_through qa=%h required %h", qa, w);
        end
        apply(1'b1, 1'b1, '0, '0, '0, 1'b0, 1'b1, 10'd5, '0, '0);
        checks++;
        if (qb !== w || qb !== exp_qb) begin
            errors++;
            $display("FAIL basic_read_b qb=%h required %h", qb, w);
        end
    endtask

    task automatic test_hold();
        logic [DW-1:0] held;
        apply(1'b0, 1'b1, 10'd5, '0, '0, 1'b1, 1'b1, '0, '0, '0);
        held = 128'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 1'b0, AW'(100 + i), {4{$urandom}}, '0, 1'b1, 1'b1, '0, '0, '0);
            checks++;
            if (qa !== held) begin
                errors++;
                $display("FAIL hold_cycle%0d qa=%h required %h", i, qa, held);
            end
        end
    endtask

    task automatic test_collision();
        apply(1'b0, 1'b0, 10'd7, 128'h11, '0, 1'b1, 1'b1, '0, '0, '0);
        apply(1'b0, 1'b1, 10'd7, '0, '0, 1'b0, 1'b0, 10'd7, 128'h22, '0);
        checks++;
        if (qa !== 128'h11 || qb !== 128'h22) begin
            errors++;
            $display("FAIL collision_rw qa=%h qb=%h required 11/22", qa, qb);
        end
        apply(1'b0, 1'b0, 10'd7, 128'h33, '0, 1'b0, 1'b0, 10'd7, 128'h44, '0);
        checks++;
        if (qa !== 128'h44 || qb !== 128'h44) begin
            errors++;
            $display("FAIL collision_ww qa=%h qb=%h required 44/44", qa, qb);
        end
        apply(1'b0, 1'b1, 10'd7, '0, '0, 1'b0, 1'b1, 10'd7, '0, '0);
        checks++;
        if (qa !== 128'h44 || qb !== 128'h44) begin
            errors++;
            $display("FAIL collision_readback qa=%h qb=%h required 44/44", qa, qb);
        end
    endtask

`ifdef S018DP_BW_EN
    task automatic test_bitwrite();
        logic [DW-1:0] req;
        req = {{(DW-8){1'b1}}, 8'h00};
        apply(1'b0, 1'b0, 10'd3, '1, '0, 1'b1, 1'b1, '0, '0, '0);
        apply(1'b0, 1'b0, 10'd3, '0, {{(DW-8){1'b1}}, 8'h00}, 1'b1, 1'b1, '0, '0, '0);
        checks++;
        if (qa !== req) begin
            errors++;
            $display("FAIL bitwrite_q qa=%h required %h", qa, req);
        end
        apply(1'b1, 1'b1, '0, '0, '0, 1'b0, 1'b1, 10'd3, '0, '0);
        checks++;
        if (qb !== req) begin
            errors++;
            $display("FAIL bitwrite_mem qb=%h required %h", qb, req);
        end
        apply(1'b0, 1'b0, 10'd3, '0, '1, 1'b1, 1'b1, '0, '0, '0);
        checks++;
        if (qa !== req) begin
            errors++;
            $display("FAIL bitwrite_noop qa=%h required %h", qa, req);
        end
    endtask
`endif

    task automatic test_sweep();
        logic [DW-1:0] w;
        for (int i = 0; i < DEPTH; i++) begin
            w = DW'(i ^ 32'h3FF);
            apply(1'b1, 1'b1, '0, '0, '0, 1'b0, 1'b0, AW'(i), w, '0);
        end
        for (int i = 0; i < DEPTH; i++) begin
            w = DW'(i ^ 32'h3FF);
            apply(1'b0, 1'b1, AW'(i), '0, '0, 1'b1, 1'b1, '0, '0, '0);
            checks++;
            if (qa !== w) begin
                errors++;
                $display("FAIL sweep_addr%0d qa=%h required %h", i, qa, w);
            end
        end
    endtask

    task automatic test_random();
        logic          ca, wa, cb, wb;
        logic [AW-1:0] a1, a2;
        logic [DW-1:0] d1, d2, m1, m2;
        for (int i = 0; i < 400; i++) begin
            ca = ($urandom_range(0, 3) == 0);
            cb = ($urandom_range(0, 3) == 0);
            wa = $urandom_range(0, 1) == 1;
            wb = $urandom_range(0, 1) == 1;
            a1 = ($urandom_range(0, 7) == 0) ? AW'(DEPTH - 1) : AW'($urandom_range(0, 7));
            a2 = ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom_range(0, 7));
            d1 = {$urandom, $urandom, $urandom, $urandom};
            d2 = {$urandom, $urandom, $urandom, $urandom};
            m1 = '0;
            m2 = '0;
`ifdef S018DP_BW_EN
            m1 = {$urandom, $urandom, $urandom, $urandom};
            m2 = {$urandom, $urandom, $urandom, $urandom};
`endif
            apply(ca, wa, a1, d1, m1, cb, wb, a2, d2, m2);
            checks++;
            if (qa !== exp_qa) begin
                errors++;
                $display("FAIL random%0d_qa qa=%h required %h", i, qa, exp_qa);
            end
            checks++;
            if (qb !== exp_qb) begin
                errors++;
                $display("FAIL random%0d_qb qb=%h required %h", i, qb, exp_qb);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [DW-1:0] pat, keep;
        pat = {16{8'hA5}};
        apply(1'b0, 1'b0, 10'd9, pat, '0, 1'b0, 1'b1, 10'd9, '0, '0);
        checks++;
        if (qa !== pat) begin
            errors++;
            $display("FAIL areset_setup qa=%h required %h", qa, pat);
        end
        keep = ref_mem[20];
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (qa !== '0 || qb !== '0) begin
            errors++;
            $display("FAIL areset_immediate qa=%h qb=%h required 0", qa, qb);
        end
        apply(1'b0, 1'b0, 10'd20, '1, '0, 1'b0, 1'b0, 10'd9, '0, '0);
        checks++;
        if (qa !== '0 || qb !== '0) begin
            errors++;
            $display("FAIL areset_held qa=%h qb=%h required 0", qa, qb);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_qa = '0;
        exp_qb = '0;
        apply(1'b0, 1'b1, 10'd9, '0, '0, 1'b0, 1'b1, 10'd20, '0, '0);
        checks++;
        if (qa !== pat) begin
            errors++;
            $display("FAIL areset_preserve_a qa=%h required %h", qa, pat);
        end
        checks++;
        if (qb !== keep) begin
            errors++;
            $display("FAIL areset_no_write qb=%h required %h", qb, keep);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        cena = 1'b1; wena = 1'b1; aa = '0; da = '0;
        cenb = 1'b1; wenb = 1'b1; ab = '0; db = '0;
`ifdef S018DP_BW_EN
        bwena = '0; bwenb = '0;
`endif
        exp_qa = '0;
        exp_qb = '0;
        test_reset();
        test_basic_rw();
        test_hold();
        test_collision();
`ifdef S018DP_BW_EN
        test_bitwrite();
`endif
        test_sweep();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
